// File: rtl/int2float_pipe.sv
// Three-stage integer-to-compact-float converter (valid/ready, full throughput).
// Optional build macro I2F_ROUND_NEAREST_EN: round-to-nearest-even with saturation in S3.
module int2float_pipe #(
  parameter int IN_W   = 11,
  parameter int MAN_W  = 3,
  parameter int EXP_W  = 4,
  parameter int SIGNED = 0,
  localparam int OUT_W = SIGNED + EXP_W + MAN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             busy
);
  localparam int LW = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int RW = IN_W - 1 - MAN_W;

  // Handshake contract: a word moves across a boundary on a cycle where
  // valid and ready are both high; an offered word is held until taken.
  logic             s1_valid, s2_valid, s3_valid;
  logic             s1_sign, s2_sign;
  logic [IN_W-1:0]  s1_mag, s2_mag;
  logic [LW-1:0]    s2_lead;
  logic             s2_zero;
  logic [OUT_W-1:0] s3_data;

  logic s1_free, s2_free, s3_free;
  assign s3_free = ~s3_valid | out_ready;
  assign s2_free = ~s2_valid | s3_free;
  assign s1_free = ~s1_valid | s2_free;

  assign in_ready  = ~rst & s1_free;
  assign out_valid = ~rst & s3_valid;
  assign busy      = ~rst & (s1_valid | s2_valid | s3_valid);
  assign out_data  = rst ? '0 : s3_data;

  logic            in_sign;
  logic [IN_W-1:0] in_mag;
  always_comb begin
    in_sign = 1'b0;
    in_mag  = in_data;
    // Negating the most negative value wraps to 2^(IN_W-1), the correct magnitude.
    if (SIGNED != 0 && in_data[IN_W-1]) begin
      in_sign = 1'b1;
      in_mag  = -in_data;
    end
  end

  logic [LW-1:0] lod_lead;
  logic          lod_zero;
  always_comb begin
    lod_lead = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (s1_mag[i]) lod_lead = LW'(i);
    end
    lod_zero = ~|s1_mag;
  end

  int               sh;
  int               e_i;
  logic [MAN_W-1:0] man_t;
  logic [OUT_W-1:0] pk;
`ifdef I2F_ROUND_NEAREST_EN
  logic [RW-1:0]    rem;
  logic             guard, sticky;
`endif
  always_comb begin
    sh    = IN_W - 1 - int'(s2_lead);
    e_i   = 0;
    man_t = s2_mag[MAN_W-1:0];
`ifdef I2F_ROUND_NEAREST_EN
    rem    = RW'(s2_mag << sh);
    guard  = rem[RW-1];
    sticky = 1'b0;
    for (int i = 0; i < RW - 1; i++) sticky = sticky | rem[i];
`endif
    if (s2_zero) begin
      man_t = '0;
    end else if (int'(s2_lead) >= MAN_W) begin
      // Left-justify so the leading one sits at the MSB; the mantissa is just below it.
      man_t = MAN_W'((s2_mag << sh) >> RW);
      e_i   = int'(s2_lead) - MAN_W + 1;
`ifdef I2F_ROUND_NEAREST_EN
      if (guard & (sticky | man_t[0])) begin
        if (&man_t) begin
          man_t = '0;
          e_i   = e_i + 1;
        end else begin
          man_t = man_t + MAN_W'(1);
        end
      end
      if (e_i > (2**EXP_W) - 1) begin
        e_i   = (2**EXP_W) - 1;
        man_t = '1;
      end
`endif
    end
    pk                 = '0;
    pk[MAN_W-1:0]      = man_t;
    pk[MAN_W +: EXP_W] = EXP_W'(e_i);
    if (SIGNED != 0) pk[OUT_W-1] = s2_sign & ~s2_zero;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_mag   <= '0;
      s2_sign  <= 1'b0;
      s2_mag   <= '0;
      s2_lead  <= '0;
      s2_zero  <= 1'b1;
      s3_data  <= '0;
    end else begin
      if (s1_free) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_sign <= in_sign;
          s1_mag  <= in_mag;
        end
      end
      if (s2_free) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_sign <= s1_sign;
          s2_mag  <= s1_mag;
          s2_lead <= lod_lead;
          s2_zero <= lod_zero;
        end
      end
      if (s3_free) begin
        s3_valid <= s2_valid;
        if (s2_valid) s3_data <= pk;
      end
    end
  end
endmodule

// File: tb/tb_int2float_pipe.sv
// Bench for int2float_pipe: default unsigned instance plus a SIGNED=1 instance,
// scoreboard queues filled at input accept and drained at output transfer.
module tb_int2float_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        u_in_valid, u_in_ready, u_out_valid, u_out_ready, u_busy;
  logic [10:0] u_in_data;
  logic [6:0]  u_out_data;
  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_busy;
  logic [10:0] s_in_data;
  logic [7:0]  s_out_data;

  int n_cmp = 0;
  int n_bad = 0;
  logic [6:0] u_q[$];
  logic [7:0] s_q[$];
  logic [6:0] u_e;
  logic [7:0] s_e;

  always #5 clk = ~clk;

  int2float_pipe u_dut (
    .clk(clk), .rst(rst), .in_valid(u_in_valid), .in_ready(u_in_ready), .in_data(u_in_data),
    .out_valid(u_out_valid), .out_ready(u_out_ready), .out_data(u_out_data), .busy(u_busy)
  );

  int2float_pipe #(.SIGNED(1)) s_dut (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data), .busy(s_busy)
  );

  // Reference: shift right until the value fits MAN_W+1 bits, then round on the remainder.
  function automatic logic [6:0] ref_u(input int mag);
    int s, m, e;
    int r, half;
    if (mag < 8) return 7'(mag);
    s = 0;
    m = mag;
    while (m >= 16) begin
      m = m >> 1;
      s++;
    end
`ifdef I2F_ROUND_NEAREST_EN
    if (s > 0) begin
      r    = mag - (m << s);
      half = 1 << (s - 1);
      if (r > half || (r == half && (m % 2) == 1)) m++;
      if (m == 16) begin
        m = 8;
        s++;
      end
    end
`endif
    e = s + 1;
    if (e > 15) begin
      e = 15;
      m = 15;
    end
    return 7'(e * 8 + (m - 8));
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      u_q.delete();
      s_q.delete();
    end else begin
      if (u_out_valid && u_out_ready) begin
        n_cmp++;
        if (u_q.size() == 0) begin
          n_bad++;
          $display("FAIL u_unexpected_output: got 0x%0h, expected no output", u_out_data);
        end else begin
          u_e = u_q.pop_front();
          if (u_out_data !== u_e) begin
            n_bad++;
            $display("FAIL u_out_data: got 0x%0h, expected 0x%0h", u_out_data, u_e);
          end
        end
      end
      if (s_out_valid && s_out_ready) begin
        n_cmp++;
        if (s_q.size() == 0) begin
          n_bad++;
          $display("FAIL s_unexpected_output: got 0x%0h, expected no output", s_out_data);
        end else begin
          s_e = s_q.pop_front();
          if (s_out_data !== s_e) begin
            n_bad++;
            $display("FAIL s_out_data: got 0x%0h, expected 0x%0h", s_out_data, s_e);
          end
        end
      end
    end
  end

  // Drivers start and end at posedge+1.
  task automatic send_u(input logic [10:0] d, input logic [6:0] e, output int waited);
    u_in_valid = 1'b1;
    u_in_data  = d;
    waited     = 0;
    @(negedge clk);
    while (!u_in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    n_cmp++;
    if (!u_in_ready) begin
      n_bad++;
      $display("FAIL u_accept_timeout: in_ready=%b after %0d cycles, expected 1", u_in_ready, waited);
    end else begin
      u_q.push_back(e);
    end
    @(posedge clk); #1;
    u_in_valid = 1'b0;
  endtask

  task automatic send_s(input logic [10:0] d, input logic [7:0] e);
    int t = 0;
    s_in_valid = 1'b1;
    s_in_data  = d;
    @(negedge clk);
    while (!s_in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (!s_in_ready) begin
      n_bad++;
      $display("FAIL s_accept_timeout: in_ready=%b, expected 1", s_in_ready);
    end else begin
      s_q.push_back(e);
    end
    @(posedge clk); #1;
    s_in_valid = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    int t = 0;
    @(negedge clk);
    while ((u_q.size() != 0 || u_busy) && t < 200) begin
      @(negedge clk);
      t++;
    end
    ok = (u_q.size() == 0) && !u_busy;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    u_in_valid = 1'b0; u_in_data = '0; u_out_ready = 1'b1;
    s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp += 5;
    if (u_out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b, expected 0", u_out_valid); end
    if (u_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b, expected 0", u_busy); end
    if (u_out_data !== 7'h00) begin n_bad++; $display("FAIL rst_out_data: got 0x%0h, expected 0x0", u_out_data); end
    if (u_in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %b, expected 0", u_in_ready); end
    if (s_out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_s_out_valid: got %b, expected 0", s_out_valid); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (u_in_ready !== 1'b1) begin n_bad++; $display("FAIL post_rst_in_ready: got %b, expected 1", u_in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [10:0] din[4];
    logic [6:0]  dexp[4];
    int w;
    bit ok;
    din = '{11'd0, 11'd5, 11'd13, 11'd2047};
`ifdef I2F_ROUND_NEAREST_EN
    dexp = '{7'h00, 7'h05, 7'h0D, 7'h48};
`else
    dexp = '{7'h00, 7'h05, 7'h0D, 7'h47};
`endif
    u_out_ready = 1'b1;
    fork
      for (int i = 0; i < 4; i++) send_u(din[i], dexp[i], w);
      begin
        @(negedge clk);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (u_out_valid !== 1'b0) begin n_bad++; $display("FAIL latency_early: out_valid=%b at cycle 2, expected 0", u_out_valid); end
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          n_cmp++;
          if (u_out_valid !== 1'b1) begin n_bad++; $display("FAIL latency_stream: out_valid=%b at cycle %0d, expected 1", u_out_valid, k + 3); end
        end
      end
    join
    wait_idle(ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL b2b_drain: queue=%0d busy=%b, expected 0 0", u_q.size(), u_busy); end
  endtask

  task automatic test_round;
    int w;
    bit ok;
    u_out_ready = 1'b1;
    send_u(11'd100, 7'h24, w);
`ifdef I2F_ROUND_NEAREST_EN
    send_u(11'd108, 7'h26, w);
    send_u(11'd2047, 7'h48, w);
`else
    send_u(11'd108, 7'h25, w);
    send_u(11'd2047, 7'h47, w);
`endif
    send_u(11'd1024, 7'h40, w);
    send_u(11'd7, 7'h07, w);
    send_u(11'd8, 7'h08, w);
    wait_idle(ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL round_drain: queue=%0d busy=%b, expected 0 0", u_q.size(), u_busy); end
  endtask

  task automatic test_signed;
    int t = 0;
    send_s(11'h7F3, 8'h8D);
    send_s(11'h400, 8'hC0);
    send_s(11'd13, 8'h0D);
    send_s(11'h7FF, 8'h81);
    @(negedge clk);
    while ((s_q.size() != 0 || s_busy) && t < 50) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (s_q.size() != 0 || s_busy) begin n_bad++; $display("FAIL signed_drain: queue=%0d busy=%b, expected 0 0", s_q.size(), s_busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    logic [10:0] din[6];
    logic [6:0]  cap;
    int accepted = 0;
    int w;
    bit ok;
    din = '{11'd1, 11'd100, 11'd300, 11'd513, 11'd1000, 11'd2000};
    u_out_ready = 1'b0;
    fork
      for (int i = 0; i < 6; i++) begin
        send_u(din[i], ref_u(int'(din[i])), w);
        accepted++;
      end
      begin
        repeat (3) @(negedge clk);
        cap = 7'h00;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          n_cmp += 3;
          if (accepted != 3 || u_in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_in_ready: accepted=%0d in_ready=%b, expected 3 0", accepted, u_in_ready);
          end
          if (u_out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_out_valid: got %b, expected 1", u_out_valid); end
          if (k == 0) begin
            cap = ref_u(int'(din[0]));
          end
          if (u_out_data !== cap) begin n_bad++; $display("FAIL bp_stable: got 0x%0h, expected 0x%0h", u_out_data, cap); end
        end
        @(posedge clk); #1;
        u_out_ready = 1'b1;
      end
    join
    wait_idle(ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL bp_drain: queue=%0d busy=%b, expected 0 0", u_q.size(), u_busy); end
  endtask

  task automatic test_bubble;
    int w;
    int t = 0;
    bit ok;
    u_out_ready = 1'b0;
    send_u(11'd40, ref_u(40), w);
    @(negedge clk);
    while (!u_out_valid && t < 10) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (u_out_valid !== 1'b1) begin n_bad++; $display("FAIL bubble_first: out_valid=%b, expected 1", u_out_valid); end
    @(posedge clk); #1;
    send_u(11'd41, ref_u(41), w);
    n_cmp++;
    if (w != 0) begin n_bad++; $display("FAIL bubble_accept1: waited %0d, expected 0", w); end
    send_u(11'd900, ref_u(900), w);
    n_cmp++;
    if (w != 0) begin n_bad++; $display("FAIL bubble_accept2: waited %0d, expected 0", w); end
    @(negedge clk);
    n_cmp += 2;
    if (u_busy !== 1'b1) begin n_bad++; $display("FAIL bubble_busy: got %b, expected 1", u_busy); end
    if (u_in_ready !== 1'b0) begin n_bad++; $display("FAIL bubble_full: in_ready=%b, expected 0", u_in_ready); end
    @(posedge clk); #1;
    u_out_ready = 1'b1;
    wait_idle(ok);
    n_cmp++;
    if (!ok || u_busy !== 1'b0) begin n_bad++; $display("FAIL bubble_idle: queue=%0d busy=%b, expected 0 0", u_q.size(), u_busy); end
  endtask

  task automatic test_reset_mid;
    int w;
    u_out_ready = 1'b0;
    send_u(11'd3, ref_u(3), w);
    send_u(11'd30, ref_u(30), w);
    send_u(11'd300, ref_u(300), w);
    @(negedge clk);
    n_cmp++;
    if (u_busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy_before: got %b, expected 1", u_busy); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp += 2;
    if (u_out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_out_valid: got %b, expected 0", u_out_valid); end
    if (u_busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy: got %b, expected 0", u_busy); end
    @(posedge clk); #1;
    rst = 1'b0;
    u_out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_cmp++;
      if (u_out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_stale: out_valid=%b data=0x%0h, expected 0", u_out_valid, u_out_data); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    logic [10:0] d;
    int w;
    bit ok;
    fork
      for (int i = 0; i < 30; i++) begin
        d = 11'($urandom_range(0, 2047));
        send_u(d, ref_u(int'(d)), w);
      end
      begin
        for (int k = 0; k < 120; k++) begin
          @(posedge clk); #1;
          u_out_ready = 1'($urandom_range(0, 1));
        end
        u_out_ready = 1'b1;
      end
    join
    wait_idle(ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL random_drain: queue=%0d busy=%b, expected 0 0", u_q.size(), u_busy); end
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_round;
    test_signed;
    test_backpressure;
    test_bubble;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/int2float_pipe.md
Name: int2float_pipe

Overview:
- Parametrised, pipelined successor to the fixed 11-bit-to-7-bit integer-to-float converter.
- Converts an IN_W-bit integer to a compact float {sign, exponent, mantissa} with an implicit leading one.
- Generalised in input width, mantissa width and signedness; uses a valid/ready streaming interface with backpressure.
- Sits between integer datapath producers and downstream float consumers, such as the compressors and activation units.

Parameters:
IN_W, 11, integer input width (>= MAN_W+2)
MAN_W, 3, stored mantissa bits (leading one implicit)
EXP_W, 4, exponent width; must satisfy 2^EXP_W-1 >= IN_W-MAN_W+1
SIGNED, 0, 1 = input is two's complement, output gets a sign MSB; 0 = unsigned, no sign bit
OUT_W, SIGNED+EXP_W+MAN_W, derived; not to be overridden

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  input word present
in_ready  out  1  block can accept input this cycle
in_data  in  IN_W  integer operand
out_valid  out  1  result present
out_ready  in  1  consumer accepts result this cycle
out_data  out  OUT_W  {sign (if SIGNED), exp[EXP_W-1:0], man[MAN_W-1:0]}
busy  out  1  any pipeline stage holds a valid entry

Behaviour:
- Transfer rules:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
- Three register stages S1, S2, S3, each with its own valid bit:
  - S1: capture sign and magnitude. For SIGNED, magnitude = |x|, and the most negative value yields magnitude 2^(IN_W-1).
  - S2: leading-one detect. Produces lead index L (0..IN_W-1) and a zero flag.
  - S3: normalise, (round), pack; drives out_data.
- Latency: 3 cycles from input transfer to out_valid with no stall. Throughput: 1 result/cycle.
- Stage advance:
  - A stage advances when the next stage is empty or advancing.
  - S3 advances when out_ready is high.
  - in_ready = ~S1.valid | S1 advancing, i.e. purely combinational from downstream state.
  - Bubbles collapse: an empty stage accepts data even while later stages stall.
- Stall: while out_valid & ~out_ready, out_data and all stage contents hold stable. No loss, no duplication, strict FIFO order.
- Encoding:
  - Zero: exp=0, man=0, sign=0.
  - L < MAN_W: exp=0, man = magnitude[MAN_W-1:0] (exact, subnormal-like).
  - L >= MAN_W: exp = L-MAN_W+1; man = the MAN_W bits immediately below the leading one.
  - Bits below the mantissa are truncated (default).
- Decoded value: exp=0 -> man; exp>0 -> (2^MAN_W+man) << (exp-1). Monotonic and continuous.
- Reset:
  - All valid bits clear on the next clock edge when rst=1, including mid-stream; in-flight data is discarded.
  - During reset: out_valid=0, busy=0, out_data=0, in_ready=0.
  - in_ready=1 from the first cycle after rst deasserts.
- Simultaneous accept and emit at full pipeline is legal every cycle.
- busy = S1.valid | S2.valid | S3.valid.

Optional Feature:
- Macro: I2F_ROUND_NEAREST_EN.
- Defined: S3 rounds to nearest, ties to even, on the discarded bits (guard = first discarded bit, sticky = OR of the rest).
  - A mantissa carry-out sets man=0 and increments exp.
  - If exp would exceed 2^EXP_W-1, the result saturates to exp all-ones, man all-ones.
  - Latency is unchanged.
- Undefined: truncation only; no rounding or saturation logic is present.

Test Plan:
- Defaults, unsigned, out_ready=1, inputs 0, 5, 13, 2047 back-to-back -> out_data 0x00, 0x05, 0x0D, 0x47 on cycles 3..6 after the first accept, out_valid continuous.
- Inputs 100 and 108:
  - truncate build -> 0x24, 0x25.
  - I2F_ROUND_NEAREST_EN build -> 0x24 (tie, even kept), 0x26 (tie, rounded up).
  - Same build: 2047 -> 0x48 (mantissa carry into exp=9).
- SIGNED=1, inputs -13 and -1024 -> 0x8D, 0xC0; input +13 -> 0x0D.
- Backpressure: stream 6 words with out_ready=0 for 5 cycles:
  - in_ready falls after 3 accepts; out_data is stable throughout.
  - On release, all 6 results emerge in order, none lost or duplicated.
- Bubble collapse: accept 1 word, hold out_ready=0, then offer 2 more -> both accepted while S3 stalls; busy=1 until the last result is taken, then busy=0.
- Reset mid-stream: assert rst with 3 valid entries in flight -> next edge out_valid=0, busy=0; no stale result appears after rst deasserts.
